// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle main control FSM.
// The opcode constants are also used by the ALU control decoder.
package multicycle_control_pkg;

    localparam int OPC_BITS = 11;
    typedef logic [OPC_BITS-1:0] opc_t;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        EXEC_R  = 4'd3,
        WB_R    = 4'd4,
        ADDR    = 4'd5,
        MEM_RD  = 4'd6,
        WB_LD   = 4'd7,
        MEM_WR  = 4'd8,
        BR_CBZ  = 4'd9,
        BR_B    = 4'd10,
        ILLEGAL = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_LOAD,
        CLS_STORE,
        CLS_CBZ,
        CLS_B,
        CLS_ILL
    } opclass_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam opc_t OPC_ADD  = 11'b100_0101_1000;
    localparam opc_t OPC_SUB  = 11'b110_0101_1000;
    localparam opc_t OPC_AND  = 11'b100_0101_0000;
    localparam opc_t OPC_ORR  = 11'b101_0101_0000;
    localparam opc_t OPC_LDUR = 11'b111_1100_0010;
    localparam opc_t OPC_STUR = 11'b111_1100_0000;

    // CBZ is identified by its top 8 bits, B by its top 6 bits.
    localparam opc_t OPC_CBZ      = 11'b101_1010_0000;
    localparam opc_t OPC_CBZ_MASK = 11'b111_1111_1000;
    localparam opc_t OPC_B        = 11'b000_1010_0000;
    localparam opc_t OPC_B_MASK   = 11'b111_1110_0000;

    function automatic logic opc_match(input opc_t opc, input opc_t value, input opc_t mask);
        return (opc & mask) == (value & mask);
    endfunction

endpackage

// File: rtl/multicycle_control_opcode_class.sv
// Combinational opcode classifier: maps an 11-bit LEGv8 opcode to its
// instruction class (R-type, load, store, CBZ, B or illegal).
module mc_opcode_class
    import multicycle_control_pkg::*;
(
    input  opc_t     opc,
    output opclass_t cls
);

    always_comb begin
        cls = CLS_ILL;
        if (opc == OPC_ADD || opc == OPC_SUB || opc == OPC_AND || opc == OPC_ORR) begin
            cls = CLS_RTYPE;
        end else if (opc == OPC_LDUR) begin
            cls = CLS_LOAD;
        end else if (opc == OPC_STUR) begin
            cls = CLS_STORE;
        end else if (opc_match(opc, OPC_CBZ, OPC_CBZ_MASK)) begin
            cls = CLS_CBZ;
        end else if (opc_match(opc, OPC_B, OPC_B_MASK)) begin
            cls = CLS_B;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// LEGv8 multi-cycle main control FSM with memory handshake and retire counter.
// Define MC_ILLEGAL_TRAP_EN to hold in ILLEGAL until reset instead of retiring a NOP.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPC_W = 11,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opCode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic [1:0]       ALUOp,
    output logic             Reg2Loc,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrcUncond,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    state_t   state_q, state_d;
    opc_t     opc_q;
    opc_t     opc_sel;
    opclass_t cls;
    logic     retire;

    // Branch in DECODE on the incoming opcode (the value being latched);
    // everywhere else only the latched copy is visible.
    assign opc_sel = (state_q == DECODE) ? opc_t'(opCode) : opc_q;

    mc_opcode_class u_class (
        .opc (opc_sel),
        .cls (cls)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opc_q       <= '0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                opc_q <= opc_t'(opCode);
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // NOTE: every output gets a default before the case so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        mem_req     = 1'b0;
        ALUOp       = ALUOP_ADD;
        Reg2Loc     = 1'b0;
        ALUSrc      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCSrcUncond = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (cls)
                    CLS_RTYPE:           state_d = EXEC_R;
                    CLS_LOAD, CLS_STORE: state_d = ADDR;
                    CLS_CBZ:             state_d = BR_CBZ;
                    CLS_B:               state_d = BR_B;
                    default:             state_d = ILLEGAL;
                endcase
            end
            EXEC_R: begin
                ALUOp   = ALUOP_RTYPE;
                state_d = WB_R;
            end
            WB_R: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            ADDR: begin
                ALUSrc  = 1'b1;
                state_d = (cls == CLS_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    state_d = WB_LD;
                end
            end
            WB_LD: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            MEM_WR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                Reg2Loc  = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            BR_CBZ: begin
                ALUOp   = ALUOP_PASSB;
                Reg2Loc = 1'b1;
                PCWrite = zero;
                retire  = 1'b1;
                state_d = FETCH;
            end
            BR_B: begin
                PCWrite     = 1'b1;
                PCSrcUncond = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            ILLEGAL: begin
                illegal = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
                state_d = ILLEGAL;
`else
                retire  = 1'b1;
                state_d = FETCH;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the LEGv8 datapath.
- Decodes the 11-bit instruction opcode and sequences fetch, decode, execute, memory and writeback.
- Produces the 2-bit ALUOp consumed by the ALU control decoder, plus all datapath enables.
- Sits between the instruction register / memory interface and the datapath; includes a memory request/ready handshake and a retired-instruction counter.

Parameters:
- OPC_W, 11, opcode field width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- opCode  input  OPC_W  instruction bits [31:21] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- mem_req  output  1  memory access request
- ALUOp  output  2  00 add (address/PC), 01 pass-B (CBZ), 10 R-type funct decode
- Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, IRWrite, PCWrite, PCSrcUncond  output  1 each  datapath controls
- illegal  output  1  unrecognised opcode seen
- instr_count  output  CNT_W  retired instructions
- state  output  4  current FSM state, for debug

Behaviour:
- Reset is asynchronous and active-low.
- During and after reset: state=IDLE, all outputs 0, instr_count=0, internal opcode latch=0. Asserting reset mid-instruction aborts immediately; no partial write is retired.
- All control outputs are Moore outputs, decoded from state and the latched opcode. They are registered-state-driven: no combinational path from opCode to outputs.
- Recognised opcodes:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - LDUR 11111000010, STUR 11111000000
  - CBZ 10110100xxx
  - B 000101xxxxx
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: mem_req=1, MemRead=1, ALUOp=00. Stay while mem_ready=0. When mem_ready=1: IRWrite=1 and PCWrite=1 (PC+4) in that same cycle, then go to DECODE.
- DECODE: latch opCode. Branch on the latched opcode:
  - R-type → EXEC_R
  - LDUR/STUR → ADDR
  - CBZ → BR_CBZ
  - B → BR_B
  - otherwise → ILLEGAL
- EXEC_R: ALUOp=10, ALUSrc=0, Reg2Loc=0. Next state WB_R.
- WB_R: RegWrite=1, MemtoReg=0. Retire. Next state FETCH.
- ADDR: ALUOp=00, ALUSrc=1. Next state MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: mem_req=1, MemRead=1. Wait for mem_ready, then go to WB_LD.
- WB_LD: RegWrite=1, MemtoReg=1. Retire. Next state FETCH.
- MEM_WR: mem_req=1, MemWrite=1, Reg2Loc=1. Wait for mem_ready; retire on mem_ready. Next state FETCH.
- BR_CBZ: ALUOp=01, Reg2Loc=1, PCWrite=zero. Retire. Next state FETCH.
- BR_B: PCWrite=1, PCSrcUncond=1. Retire. Next state FETCH.
- Latency with zero-wait memory (mem_ready=1 on first request cycle):
  - R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3.
  - Each wait cycle adds one.
- Retire: instr_count increments by 1 in the retire cycle and wraps modulo 2^CNT_W.
- mem_req stays high and its qualifiers stay stable until mem_ready. mem_ready outside a request state is ignored.
- Changes on opCode after DECODE are ignored until the next DECODE.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: ILLEGAL sets illegal=1 and holds in ILLEGAL (all other outputs 0) until reset; no retire.
- Undefined: ILLEGAL pulses illegal=1 for one cycle, retires as a NOP (instr_count increments), then goes to FETCH.

Decomposition:
- Shared package holds:
  - state enum: IDLE, FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_LD, MEM_WR, BR_CBZ, BR_B, ILLEGAL
  - ALUOp encodings: ALUOP_ADD, ALUOP_PASSB, ALUOP_RTYPE
  - opcode constants and masks (CBZ 8-bit, B 6-bit prefix)
- The same opcode constants are reused by the ALU control decoder.
- One sub-module, mc_opcode_class: combinational opcode to class {RTYPE, LOAD, STORE, CBZ, B, ILL}.

Test Plan:
- Release reset, opCode=10001011000, mem_ready=1 → states IDLE,FETCH,DECODE,EXEC_R,WB_R; ALUOp=10 in EXEC_R; RegWrite=1 in WB_R; instr_count=1.
- LDUR 11111000010, mem_ready low 2 cycles in MEM_RD → MEM_RD held 3 cycles with mem_req=1; WB_LD has MemtoReg=1, RegWrite=1; total 7 cycles.
- CBZ 10110100101 with zero=1, then zero=0 → PCWrite=1 in BR_CBZ with ALUOp=01, then PCWrite=0; instr_count +2.
- STUR then B 00010100000 → MemWrite=1 only in MEM_WR; BR_B asserts PCWrite=1, PCSrcUncond=1; 7 cycles total.
- Opcode 11111111111 → with MC_ILLEGAL_TRAP_EN, illegal stays 1 and state=ILLEGAL; without it, illegal pulses one cycle, instr_count+1, FETCH follows.
- rst_n low during MEM_WR wait → all outputs 0 asynchronously, instr_count=0; restarts at IDLE.
